// File: rtl/vga_pattern_gen.sv
// Per-pixel RGB test-pattern generator fed by the VGA timing generator's disp_ena/col/row.
// Latency: fixed 2 cycles from disp_ena/col/row to de_out/red/green/blue; sof is stage-1 aligned (1 cycle).
// Backpressure: none; streaming pixel pipeline that accepts one pixel every clock.
//
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   disp_ena, col, row active-video flag and pixel coordinates from the timing generator
//   mode               requested pattern (0 bars, 1 checker, 2 grid, 3 bouncing box), latched at frame start
//   de_out             disp_ena delayed to line up with the colour outputs
//   red, green, blue   pixel colour, black whenever the delayed display-enable is low
//   sof                one-cycle start-of-frame pulse
// Optional build macro PATTERN_CROSSHAIR_EN: overlays a white crosshair through the screen centre.
module vga_pattern_gen #(
    parameter int H_PIXELS = 150,
    parameter int V_PIXELS = 75,
    parameter int H_BITS   = 8,
    parameter int V_BITS   = 7,
    parameter int RGB_BITS = 4,
    parameter int BOX      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp_ena,
    input  logic [H_BITS-1:0]   col,
    input  logic [V_BITS-1:0]   row,
    input  logic [1:0]          mode,
    output logic                de_out,
    output logic [RGB_BITS-1:0] red,
    output logic [RGB_BITS-1:0] green,
    output logic [RGB_BITS-1:0] blue,
    output logic                sof
);

    localparam int                BAR_W = H_PIXELS / 8;
    localparam logic [H_BITS-1:0] X_MAX = H_BITS'(H_PIXELS - BOX);
    localparam logic [V_BITS-1:0] Y_MAX = V_BITS'(V_PIXELS - BOX);

    // Stage 1 registers; r_ena1 doubles as the previous-cycle disp_ena (ena_d)
    logic              r_ena1;
    logic [H_BITS-1:0] r_col1;
    logic [V_BITS-1:0] r_row1;
    logic              r_sof;

    // Per-frame state
    logic [1:0]        r_active_mode;
    logic [H_BITS-1:0] r_box_x;
    logic [V_BITS-1:0] r_box_y;
    logic              r_dir_x;   // 1 = moving right
    logic              r_dir_y;   // 1 = moving down

    logic              w_sof_det;
    logic [H_BITS-1:0] w_box_x_nxt;
    logic [V_BITS-1:0] w_box_y_nxt;
    logic              w_dir_x_nxt;
    logic              w_dir_y_nxt;

    // A frame starts only when active video rises exactly at the origin.
    assign w_sof_det = disp_ena & ~r_ena1 & (row == '0) & (col == '0);
    assign sof       = r_sof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena1 <= 1'b0;
            r_col1 <= '0;
            r_row1 <= '0;
            r_sof  <= 1'b0;
        end else begin
            r_ena1 <= disp_ena;
            r_col1 <= col;
            r_row1 <= row;
            r_sof  <= w_sof_det;
        end
    end

    // Bounce: at an edge the direction flips and the step is taken in the new
    // direction in the same update, so the box never pauses at a wall.
    always_comb begin
        w_box_x_nxt = r_box_x;
        w_dir_x_nxt = r_dir_x;
        if (r_dir_x) begin
            if (r_box_x >= X_MAX) begin
                w_dir_x_nxt = 1'b0;
                w_box_x_nxt = r_box_x - 1'b1;
            end else begin
                w_box_x_nxt = r_box_x + 1'b1;
            end
        end else begin
            if (r_box_x == '0) begin
                w_dir_x_nxt = 1'b1;
                w_box_x_nxt = r_box_x + 1'b1;
            end else begin
                w_box_x_nxt = r_box_x - 1'b1;
            end
        end
    end

    always_comb begin
        w_box_y_nxt = r_box_y;
        w_dir_y_nxt = r_dir_y;
        if (r_dir_y) begin
            if (r_box_y >= Y_MAX) begin
                w_dir_y_nxt = 1'b0;
                w_box_y_nxt = r_box_y - 1'b1;
            end else begin
                w_box_y_nxt = r_box_y + 1'b1;
            end
        end else begin
            if (r_box_y == '0) begin
                w_dir_y_nxt = 1'b1;
                w_box_y_nxt = r_box_y + 1'b1;
            end else begin
                w_box_y_nxt = r_box_y - 1'b1;
            end
        end
    end

    // Mode and box position change only at frame start, so a whole frame
    // is always drawn with one consistent pattern and box position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_mode <= 2'd0;
            r_box_x       <= '0;
            r_box_y       <= '0;
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
        end else if (w_sof_det) begin
            r_active_mode <= mode;
            r_box_x       <= w_box_x_nxt;
            r_box_y       <= w_box_y_nxt;
            r_dir_x       <= w_dir_x_nxt;
            r_dir_y       <= w_dir_y_nxt;
        end
    end

    // Stage 2 colour: every pattern is full-or-zero per channel, so work
    // with one flag per channel {r,g,b} and widen at the register.
    logic [H_BITS-1:0] w_bar_q;
    logic [2:0]        w_bar_idx;
    logic [H_BITS:0]   w_col_ext;
    logic [H_BITS:0]   w_bx_end;
    logic [V_BITS:0]   w_row_ext;
    logic [V_BITS:0]   w_by_end;
    logic              w_in_box;
    logic [2:0]        w_rgb;

    assign w_bar_q   = r_col1 / H_BITS'(BAR_W);
    assign w_bar_idx = (w_bar_q > H_BITS'(7)) ? 3'd7 : w_bar_q[2:0];

    // One extra bit so box_x+BOX never wraps near the right/bottom edge.
    assign w_col_ext = {1'b0, r_col1};
    assign w_row_ext = {1'b0, r_row1};
    assign w_bx_end  = {1'b0, r_box_x} + (H_BITS+1)'(BOX);
    assign w_by_end  = {1'b0, r_box_y} + (V_BITS+1)'(BOX);
    assign w_in_box  = (w_col_ext >= {1'b0, r_box_x}) && (w_col_ext < w_bx_end) &&
                       (w_row_ext >= {1'b0, r_box_y}) && (w_row_ext < w_by_end);

    always_comb begin
        w_rgb = 3'b000;
        case (r_active_mode)
            // Bar order white,yellow,cyan,green,magenta,red,blue,black
            // reduces to each channel being one inverted index bit.
            2'd0:    w_rgb = {~w_bar_idx[1], ~w_bar_idx[2], ~w_bar_idx[0]};
            2'd1:    w_rgb = {3{r_col1[3] ^ r_row1[3]}};
            2'd2:    w_rgb = {3{(r_col1[3:0] == 4'd0) || (r_row1[3:0] == 4'd0)}};
            default: w_rgb = w_in_box ? 3'b100 : 3'b001;
        endcase
`ifdef PATTERN_CROSSHAIR_EN
        if ((r_col1 == H_BITS'(H_PIXELS / 2)) || (r_row1 == V_BITS'(V_PIXELS / 2))) begin
            w_rgb = 3'b111;
        end
`else
`endif
        if (!r_ena1) begin
            w_rgb = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            de_out <= r_ena1;
            red    <= {RGB_BITS{w_rgb[2]}};
            green  <= {RGB_BITS{w_rgb[1]}};
            blue   <= {RGB_BITS{w_rgb[0]}};
        end
    end

endmodule
